// File: rtl/mips_pkg.sv
// Shared MIPS-32 front-end definitions: sequencer states and fetch-path constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_e;

  localparam int unsigned PC_INCR = 4;
  localparam int unsigned JIDX_W  = 26;

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Next-PC priority mux: jump over taken branch over sequential flow.
module pc_sequencer_next_pc_sel
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  i_pc_plus4,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic [WIDTH-1:0]  i_branch_target,
  input  logic              i_jump,
  input  logic [JIDX_W-1:0] i_jump_index,
  output logic [WIDTH-1:0]  o_next_pc,
  output logic              o_misalign
);

  logic [WIDTH-1:0] w_jump_pc;

  // J-class keeps the 256 MB region of the delay-slot address.
  assign w_jump_pc = {i_pc_plus4[WIDTH-1:WIDTH-4], i_jump_index, 2'b00};

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jump_pc;
    end else if (i_branch && i_zero) begin
      o_next_pc = i_branch_target;
    end
  end

  assign o_misalign = (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, sequences fetch over a ready handshake,
// traps on a misaligned next-PC and counts retired instructions.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WIDTH    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_stall,
  input  logic              i_imem_ready,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic [WIDTH-1:0]  i_branch_target,
  input  logic              i_jump,
  input  logic [JIDX_W-1:0] i_jump_index,
  output logic [WIDTH-1:0]  o_pc,
  output logic [WIDTH-1:0]  o_pc_plus4,
  output logic              o_fetch_req,
  output logic              o_misalign,
  output logic [31:0]       o_retired
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic             r_fetch_req;
  logic             r_misalign;
  logic [31:0]      r_retired;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_next_misalign;
  logic             w_retire;
  logic             w_pc_load;
  logic             w_trap;

  assign w_pc_plus4 = r_pc + WIDTH'(PC_INCR);

  pc_sequencer_next_pc_sel #(
    .WIDTH (WIDTH)
  ) u_next_pc_sel (
    .i_pc_plus4      (w_pc_plus4),
    .i_branch        (i_branch),
    .i_zero          (i_zero),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_index    (i_jump_index),
    .o_next_pc       (w_next_pc),
    .o_misalign      (w_next_misalign)
  );

  // Dropping i_en outranks a retire in the same cycle.
  assign w_retire = (r_state == FETCH) && i_en && i_imem_ready && !i_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_trap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (w_retire) begin
          if (w_next_misalign) begin
            w_state_nxt = TRAP;
            w_trap      = 1'b1;
          end else begin
            w_pc_load = 1'b1;
          end
        end
      end
      TRAP: begin
        w_state_nxt = TRAP;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A faulting instruction still counts as retired; only the PC freezes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_fetch_req <= 1'b0;
      r_misalign  <= 1'b0;
      r_retired   <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_req <= (w_state_nxt == FETCH);
      if (w_pc_load) begin
        r_pc <= w_next_pc;
      end
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
      end
      if (w_trap) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_fetch_req = r_fetch_req;
  assign o_misalign  = r_misalign;
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a reference model checked every cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] btgt = 32'd0;
  logic        jump = 1'b0;
  logic [25:0] jidx = 26'd0;
  logic [31:0] pc, pc_plus4, retired;
  logic        fetch_req, misalign;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .WIDTH(32)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (en),
    .i_stall         (stall),
    .i_imem_ready    (ready),
    .i_branch        (branch),
    .i_zero          (zero),
    .i_branch_target (btgt),
    .i_jump          (jump),
    .i_jump_index    (jidx),
    .o_pc            (pc),
    .o_pc_plus4      (pc_plus4),
    .o_fetch_req     (fetch_req),
    .o_misalign      (misalign),
    .o_retired       (retired)
  );

  always #5 clk = ~clk;

  // Reference model: running = fetching, trapped = halted until reset.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_running;
  logic        m_trapped;

  function automatic logic [31:0] target_of(input logic [31:0] cur_pc);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (jump)                return {seq[31:28], jidx, 2'b00};
    else if (branch && zero) return btgt;
    else                     return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc      <= 32'd0;
      m_ret     <= 32'd0;
      m_running <= 1'b0;
      m_trapped <= 1'b0;
    end else if (!m_trapped) begin
      if (!m_running) begin
        m_running <= en;
      end else if (!en) begin
        m_running <= 1'b0;
      end else if (ready && !stall) begin
        m_ret <= m_ret + 32'd1;
        if (target_of(m_pc) % 4 != 0) begin
          m_trapped <= 1'b1;
          m_running <= 1'b0;
        end else begin
          m_pc <= target_of(m_pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if ($time > 6) begin
      chk("cyc_pc",        pc,                 m_pc);
      chk("cyc_pc_plus4",  pc_plus4,           m_pc + 32'd4);
      chk("cyc_fetch_req", {31'd0, fetch_req}, {31'd0, m_running});
      chk("cyc_misalign",  {31'd0, misalign},  {31'd0, m_trapped});
      chk("cyc_retired",   retired,            m_ret);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    en    = 1'b1;
    ready = 1'b1;
    #12 rst_n = 1'b1;
    chk("start_pc_idle", pc, 32'h0);
    chk("start_freq_idle", {31'd0, fetch_req}, 32'd0);
    cyc();
    chk("start_pc_fetch", pc, 32'h0);
    chk("start_freq_fetch", {31'd0, fetch_req}, 32'd1);
    cyc(); chk("seq_pc4", pc, 32'h4);
    cyc(); chk("seq_pc8", pc, 32'h8);
    cyc(); chk("seq_pcC", pc, 32'hC);
    chk("seq_retired3", retired, 32'd3);

    jump = 1'b1; jidx = 26'h40;
    cyc(); chk("jump_to_100", pc, 32'h100);
    jump = 1'b0; branch = 1'b1; zero = 1'b1; btgt = 32'h140;
    cyc(); chk("branch_taken", pc, 32'h140);
    zero = 1'b0;
    cyc(); chk("branch_not_taken", pc, 32'h144);

    zero = 1'b1; btgt = 32'h8000_0010;
    cyc(); chk("branch_high", pc, 32'h8000_0010);
    jump = 1'b1; jidx = 26'h40; btgt = 32'h140;
    cyc(); chk("jump_priority", pc, 32'h8000_0100);
    chk("retired8", retired, 32'd8);

    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", pc, 32'h8000_0100);
      chk("stall_ret", retired, 32'd8);
    end
    stall = 1'b0; ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("notready_pc", pc, 32'h8000_0100);
      chk("notready_ret", retired, 32'd8);
    end
    ready = 1'b1;
    cyc(); chk("release_pc", pc, 32'h8000_0104);
    chk("release_ret", retired, 32'd9);

    en = 1'b0;
    cyc(); chk("en_low_pc", pc, 32'h8000_0104);
    chk("en_low_ret", retired, 32'd9);
    chk("en_low_freq", {31'd0, fetch_req}, 32'd0);
    en = 1'b1;
    cyc(); chk("reenable_pc", pc, 32'h8000_0104);
    chk("reenable_freq", {31'd0, fetch_req}, 32'd1);

    branch = 1'b1; zero = 1'b1; btgt = 32'hFFFF_FFFC;
    cyc(); chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    branch = 1'b0; zero = 1'b0;
    cyc(); chk("wrap_pc", pc, 32'h0);
    chk("wrap_no_trap", {31'd0, misalign}, 32'd0);

    jump = 1'b1; jidx = 26'h80;
    cyc(); chk("jump_200", pc, 32'h200);
    jump = 1'b0; branch = 1'b1; zero = 1'b1; btgt = 32'h0000_0102;
    cyc(); chk("trap_pc", pc, 32'h200);
    chk("trap_flag", {31'd0, misalign}, 32'd1);
    chk("trap_freq", {31'd0, fetch_req}, 32'd0);
    chk("trap_ret", retired, 32'd13);
    branch = 1'b0; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = i[0]; ready = ~i[1];
      cyc();
      chk("trap_hold_pc", pc, 32'h200);
      chk("trap_hold_freq", {31'd0, fetch_req}, 32'd0);
    end

    en = 1'b1; ready = 1'b1;
    rst_n = 1'b0; #2 rst_n = 1'b1;
    chk("exit_trap_pc", pc, 32'h0);
    chk("exit_trap_flag", {31'd0, misalign}, 32'd0);
    cyc();
    jump = 1'b1; jidx = 26'h10;
    cyc(); chk("jump_40", pc, 32'h40);
    jump = 1'b0; ready = 1'b0;
    cyc(); chk("hold_40", pc, 32'h40);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_freq", {31'd0, fetch_req}, 32'd0);
    chk("async_ret", retired, 32'd0);
    chk("async_flag", {31'd0, misalign}, 32'd0);
    #3 rst_n = 1'b1;
    cyc(); cyc();
    chk("post_reset_freq", {31'd0, fetch_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
